// File: rtl/quant_part_fifo_if.sv
// quant_part_fifo_if: per-lane valid/ready handshake, data and occupancy bundle for the two-lane FIFO.
interface quant_part_fifo_if #(parameter int DW = 8, parameter int AW = 2);
    logic [1:0]    in_valid, in_ready, out_valid, out_ready, flush;
    logic [DW-1:0] in_data0, in_data1, out_data0, out_data1;
    logic [AW:0]   count0, count1;
    modport master (
        output in_valid, in_data0, in_data1, out_ready, flush,
        input  in_ready, out_valid, out_data0, out_data1, count0, count1
    );
    modport slave (
        input  in_valid, in_data0, in_data1, out_ready, flush,
        output in_ready, out_valid, out_data0, out_data1, count0, count1
    );
endinterface

// File: rtl/quant_part_fifo.sv
// quant_part_fifo: two fully independent valid/ready FIFO lanes (L = lane 0, H = lane 1).
// Lanes are written out explicitly with constant indices so no lane-1 input can reach lane-0 state.
module quant_part_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic              clk,
    input logic              rst_n,
    quant_part_fifo_if.slave s
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [DW-1:0] mem0_q [DEPTH], mem0_d [DEPTH], mem1_q [DEPTH], mem1_d [DEPTH];
    logic [AW-1:0] wptr0_q, wptr0_d, rptr0_q, rptr0_d, wptr1_q, wptr1_d, rptr1_q, rptr1_d;
    logic [AW:0]   count0_q, count0_d, count1_q, count1_d;
    logic          push0, pop0, push1, pop1, valid0, valid1;
    always_comb begin
        valid0   = count0_q != '0;
        push0    = s.in_valid[0] & (count0_q != FULL);
        pop0     = s.out_ready[0] & valid0;
        mem0_d   = mem0_q;
        if (push0) mem0_d[wptr0_q] = s.in_data0;
        wptr0_d  = s.flush[0] ? '0 : wptr0_q + AW'(push0);
        rptr0_d  = s.flush[0] ? '0 : rptr0_q + AW'(pop0);
        count0_d = s.flush[0] ? '0 : count0_q + (AW+1)'(push0) - (AW+1)'(pop0);
    end
    always_comb begin
        valid1   = count1_q != '0;
        push1    = s.in_valid[1] & (count1_q != FULL);
        pop1     = s.out_ready[1] & valid1;
        mem1_d   = mem1_q;
        if (push1) mem1_d[wptr1_q] = s.in_data1;
        wptr1_d  = s.flush[1] ? '0 : wptr1_q + AW'(push1);
        rptr1_d  = s.flush[1] ? '0 : rptr1_q + AW'(pop1);
        count1_d = s.flush[1] ? '0 : count1_q + (AW+1)'(push1) - (AW+1)'(pop1);
    end
    // Storage is deliberately left out of reset; only pointers and counts clear.
    always_ff @(posedge clk) begin
        mem0_q <= mem0_d;
        mem1_q <= mem1_d;
        if (!rst_n) begin
            wptr0_q  <= '0;
            rptr0_q  <= '0;
            count0_q <= '0;
            wptr1_q  <= '0;
            rptr1_q  <= '0;
            count1_q <= '0;
        end else begin
            wptr0_q  <= wptr0_d;
            rptr0_q  <= rptr0_d;
            count0_q <= count0_d;
            wptr1_q  <= wptr1_d;
            rptr1_q  <= rptr1_d;
            count1_q <= count1_d;
        end
    end
    assign s.in_ready  = {count1_q != FULL, count0_q != FULL};
    assign s.out_valid = {valid1, valid0};
    assign s.out_data0 = valid0 ? mem0_q[rptr0_q] : '0;
    assign s.out_data1 = valid1 ? mem1_q[rptr1_q] : '0;
    assign s.count0    = count0_q;
    assign s.count1    = count1_q;
endmodule

// File: tb/tb_quant_part_fifo.sv
// tb_quant_part_fifo: directed vector table plus hand sequences for full, flush, isolation and wrap.
module tb_quant_part_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    always #5 clk = ~clk;
    quant_part_fifo_if #(.DW(8), .AW(2)) bus ();
    quant_part_fifo #(.DW(8), .DEPTH(4), .AW(2)) dut (.clk(clk), .rst_n(rst_n), .s(bus));
    typedef struct {
        logic       rst_n;
        logic [1:0] iv;
        logic [7:0] d0, d1;
        logic [1:0] ordy, fl;
        logic [1:0] e_ov, e_ir;
        logic [7:0] e_q0, e_q1;
        logic [2:0] e_c0, e_c1;
    } vec_t;
    vec_t tv[$];
    logic [7:0] mq[$];
    function automatic vec_t mk(logic r, logic [1:0] iv, logic [7:0] d0, logic [7:0] d1,
                                logic [1:0] ordy, logic [1:0] fl, logic [1:0] eov,
                                logic [1:0] eir, logic [7:0] eq0, logic [7:0] eq1,
                                logic [2:0] ec0, logic [2:0] ec1);
        vec_t v;
        v.rst_n = r; v.iv = iv; v.d0 = d0; v.d1 = d1; v.ordy = ordy; v.fl = fl;
        v.e_ov = eov; v.e_ir = eir; v.e_q0 = eq0; v.e_q1 = eq1; v.e_c0 = ec0; v.e_c1 = ec1;
        return v;
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic drive(input logic [1:0] iv, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [1:0] ordy, input logic [1:0] fl);
        bus.in_valid = iv; bus.in_data0 = d0; bus.in_data1 = d1;
        bus.out_ready = ordy; bus.flush = fl;
    endtask
    task automatic step(input logic [1:0] iv, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] ordy, input logic [1:0] fl);
        drive(iv, d0, d1, ordy, fl);
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [7:0] m0, m1, e0, e1;
        logic       ok;
        drive(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        //         rst iv    d0     d1     ordy   fl     ov     ir     q0     q1     c0 c1
        tv.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 0, 0));
        tv.push_back(mk(1, 2'b01, 8'h11, 8'h00, 2'b00, 2'b00, 2'b01, 2'b11, 8'h11, 8'h00, 1, 0));
        tv.push_back(mk(1, 2'b01, 8'h12, 8'h00, 2'b00, 2'b00, 2'b01, 2'b11, 8'h11, 8'h00, 2, 0));
        tv.push_back(mk(1, 2'b01, 8'h13, 8'h00, 2'b00, 2'b00, 2'b01, 2'b11, 8'h11, 8'h00, 3, 0));
        tv.push_back(mk(1, 2'b01, 8'h14, 8'h00, 2'b00, 2'b00, 2'b01, 2'b10, 8'h11, 8'h00, 4, 0));
        tv.push_back(mk(1, 2'b01, 8'h99, 8'h00, 2'b00, 2'b00, 2'b01, 2'b10, 8'h11, 8'h00, 4, 0));
        tv.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 2'b01, 2'b11, 8'h12, 8'h00, 3, 0));
        tv.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 2'b01, 2'b11, 8'h13, 8'h00, 2, 0));
        tv.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 2'b01, 2'b11, 8'h14, 8'h00, 1, 0));
        tv.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 0, 0));
        tv.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 0, 0));
        tv.push_back(mk(1, 2'b11, 8'h41, 8'h31, 2'b00, 2'b00, 2'b11, 2'b11, 8'h41, 8'h31, 1, 1));
        tv.push_back(mk(1, 2'b10, 8'h00, 8'h32, 2'b00, 2'b00, 2'b11, 2'b11, 8'h41, 8'h31, 1, 2));
        tv.push_back(mk(1, 2'b10, 8'h00, 8'h77, 2'b00, 2'b10, 2'b01, 2'b11, 8'h41, 8'h00, 1, 0));
        tv.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b01, 2'b11, 8'h41, 8'h00, 1, 0));
        tv.push_back(mk(1, 2'b10, 8'h00, 8'h88, 2'b01, 2'b01, 2'b10, 2'b11, 8'h00, 8'h88, 0, 1));
        tv.push_back(mk(0, 2'b11, 8'hAA, 8'hBB, 2'b11, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 0, 0));
        tv.push_back(mk(1, 2'b01, 8'h5A, 8'h00, 2'b01, 2'b00, 2'b01, 2'b11, 8'h5A, 8'h00, 1, 0));
        tv.push_back(mk(1, 2'b01, 8'h5B, 8'h00, 2'b01, 2'b00, 2'b01, 2'b11, 8'h5B, 8'h00, 1, 0));
        tv.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 0, 0));
        foreach (tv[i]) begin
            rst_n = tv[i].rst_n;
            step(tv[i].iv, tv[i].d0, tv[i].d1, tv[i].ordy, tv[i].fl);
            m0 = (tv[i].e_ov[0] | !tv[i].rst_n) ? bus.out_data0 : 8'h00;
            m1 = (tv[i].e_ov[1] | !tv[i].rst_n) ? bus.out_data1 : 8'h00;
            e0 = (tv[i].e_ov[0] | !tv[i].rst_n) ? tv[i].e_q0 : 8'h00;
            e1 = (tv[i].e_ov[1] | !tv[i].rst_n) ? tv[i].e_q1 : 8'h00;
            chk($sformatf("vec%0d {ov,ir,c0,c1,q0,q1}", i),
                {34'd0, bus.out_valid, bus.in_ready, bus.count0, bus.count1, m0, m1},
                {34'd0, tv[i].e_ov, tv[i].e_ir, tv[i].e_c0, tv[i].e_c1, e0, e1});
        end
        rst_n = 1'b1;
        // Lane 1 held full while lane 0 streams with 1-cycle latency.
        for (int k = 0; k < 4; k++) step(2'b10, 8'h00, 8'hB0 + 8'(k), 2'b00, 2'b00);
        chk("l1_full {c1,ir}", {59'd0, bus.count1, bus.in_ready}, {59'd0, 3'd4, 2'b01});
        for (int k = 0; k < 16; k++) begin
            step(2'b01, 8'hA0 + 8'(k), 8'h00, 2'b01, 2'b00);
            chk($sformatf("stream%0d {q0,c0,ir,c1}", k),
                {48'd0, bus.out_data0, bus.count0, bus.in_ready, bus.count1},
                {48'd0, 8'hA0 + 8'(k), 3'd1, 2'b01, 3'd4});
        end
        step(2'b00, 8'h00, 8'h00, 2'b01, 2'b00);
        chk("stream_drain c0", {61'd0, bus.count0}, 64'd0);
        // Lane 0 full with simultaneous push and pop: the push is dropped.
        for (int k = 0; k < 4; k++) step(2'b01, 8'h61 + 8'(k), 8'h00, 2'b00, 2'b00);
        chk("l0_full {c0,ir0}", {60'd0, bus.count0, bus.in_ready[0]}, {60'd0, 3'd4, 1'b0});
        drive(2'b01, 8'h55, 8'h00, 2'b01, 2'b00);
        #1;
        chk("full_pop head", {55'd0, bus.out_valid[0], bus.out_data0}, {55'd0, 1'b1, 8'h61});
        @(posedge clk);
        #1;
        chk("full_pop {c0,q0}", {53'd0, bus.count0, bus.out_data0}, {53'd0, 3'd3, 8'h62});
        step(2'b01, 8'h55, 8'h00, 2'b00, 2'b00);
        chk("retry c0", {61'd0, bus.count0}, {61'd0, 3'd4});
        for (int k = 0; k < 4; k++) begin
            e0 = (k == 3) ? 8'h55 : 8'h62 + 8'(k);
            drive(2'b00, 8'h00, 8'h00, 2'b01, 2'b00);
            #1;
            chk($sformatf("drain%0d q0", k), {56'd0, bus.out_data0}, {56'd0, e0});
            @(posedge clk);
            #1;
        end
        chk("drained ov0", {63'd0, bus.out_valid[0]}, 64'd0);
        // Pointer wrap: 13 pushes against a reference queue.
        for (int k = 0; k < 13; k++) begin
            drive(2'b01, 8'hC0 + 8'(k), 8'h00, {1'b0, k > 0}, 2'b00);
            #1;
            if (k > 0) chk($sformatf("wrap%0d head", k), {56'd0, bus.out_data0}, {56'd0, mq[0]});
            ok = mq.size() < 4;
            @(posedge clk);
            #1;
            if (k > 0 && mq.size() > 0) void'(mq.pop_front());
            if (ok) mq.push_back(8'hC0 + 8'(k));
            chk($sformatf("wrap%0d c0", k), {61'd0, bus.count0}, 64'(mq.size()));
        end
        while (mq.size() > 0) begin
            drive(2'b00, 8'h00, 8'h00, 2'b01, 2'b00);
            #1;
            chk("wrap_drain head", {56'd0, bus.out_data0}, {56'd0, mq[0]});
            void'(mq.pop_front());
            @(posedge clk);
            #1;
        end
        chk("end {c0,c1,ov}", {56'd0, bus.count0, bus.count1, bus.out_valid},
            {56'd0, 3'd0, 3'd4, 2'b10});
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
